// File: rtl/acondicionador_botones.sv
// Push-button conditioner for the frequency selector: 2-FF sync, debounce,
// and single-cycle up/down pulses with optional auto-repeat while held.
module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000,
  parameter int CNT_W           = 26
) (
  input  logic clknexys,
  input  logic Reset,
  input  logic btn_up_i,
  input  logic btn_down_i,
  output logic aumf_o,
  output logic bajaf_o
);

  // state        | meaning
  // IDLE         | button released, waiting for a press
  // PRESS_WAIT   | press seen, counting stable high samples
  // HELD         | press accepted, auto-repeat timer running
  // RELEASE_WAIT | low seen while held, counting stable low samples
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] DEB_TC    = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Repeat counter runs 0..DELAY (or PERIOD) inclusive, so repeat pulses are
  // DELAY+1 / PERIOD+1 cycles apart.
  localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Channel index 0 = up, 1 = down.
  logic [1:0]       sync1;
  logic [1:0]       s;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       first_q;
  logic [1:0]       first_d;
  logic [1:0]       req;

  always_ff @(posedge clknexys or posedge Reset) begin
    if (Reset) begin
      sync1   <= '0;
      s       <= '0;
      first_q <= '0;
      aumf_o  <= 1'b0;
      bajaf_o <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1   <= {btn_down_i, btn_up_i};
      s       <= sync1;
      first_q <= first_d;
      // Same-cycle requests from both channels cancel each other.
      aumf_o  <= req[0] & ~req[1];
      bajaf_o <= req[1] & ~req[0];
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    first_d = first_q;
    req     = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == DEB_TC) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            req[i]     = 1'b1;
            first_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end else if (REPEAT_EN != 0) begin
            if (cnt_q[i] == (first_q[i] ? DELAY_TC : PERIOD_TC)) begin
              req[i]     = 1'b1;
              cnt_d[i]   = '0;
              first_d[i] = 1'b0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high resumes HELD without a new pulse.
          if (s[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_TC) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

endmodule
